// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one external WIDTH-bit ripple adder among NREQ requesters.
// Latency: response valid SETTLE clocks after the accept edge; accept-to-accept spacing SETTLE+2.
// Backpressure: one op in flight; req_ready stays low until the response handshake completes.
// Optional subtract mode (req_sub input) is enabled by defining ADDER_SHARE_SUB_EN.
module adder_share_ctrl #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 5,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_y,
`ifdef ADDER_SHARE_SUB_EN
  input  logic [NREQ-1:0]         req_sub,
`endif
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        add_x,
  output logic [WIDTH-1:0]        add_y,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_s,
  input  logic                    add_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    cnt;
  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] win_x;
  logic [WIDTH-1:0] win_y;
  logic [IDW-1:0]   next_ptr;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Operand mux for the current winner (constant slice bases keep the select simple).
  always_comb begin
    win_x = '0;
    win_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        win_x = req_x[i*WIDTH +: WIDTH];
        win_y = req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant is combinational in IDLE so the accept happens on the very next edge.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[win] = 1'b1;
  end

  assign next_ptr = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

`ifdef ADDER_SHARE_SUB_EN
  logic win_sub;

  // Subtract flag of the winner, sampled with its operands at accept.
  always_comb begin
    win_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) win_sub = req_sub[i];
    end
  end

  // Carry-in is registered: 1 for a subtract so the adder forms X + ~Y + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    add_cin <= 1'b0;
    else if (state == IDLE && found) add_cin <= win_sub;
  end
`else
  assign add_cin = 1'b0;
`endif

  // Main sequencer: accept, hold adder inputs for SETTLE clocks, present response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      add_x     <= '0;
      add_y     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            add_x  <= win_x;
`ifdef ADDER_SHARE_SUB_EN
            add_y  <= win_sub ? ~win_y : win_y;
`else
            add_y  <= win_y;
`endif
            rsp_id <= win;
            rr_ptr <= next_ptr;
            cnt    <= CW'(SETTLE);
            state  <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            rsp_sum   <= add_s;
            rsp_cout  <= add_cout;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl (NREQ=4, WIDTH=5, SETTLE=2).
// The shared ripple adder is modelled as a combinational add of the driven inputs.
module tb_adder_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [19:0] req_x = '0;
  logic [19:0] req_y = '0;
  logic [3:0]  req_ready;
  logic [4:0]  add_x, add_y, add_s;
  logic        add_cin, add_cout;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_sum;
  logic        rsp_cout;

  int checks = 0;
  int failures = 0;

  adder_share_ctrl #(.NREQ(4), .WIDTH(5), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {5'b0, add_cin};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (req_ready !== 4'b0 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc %0d: req_ready=%b rsp_valid=%b, want 0000/0", c, req_ready, rsp_valid);
      end
    end
    checks++;
    if ({add_x, add_y, add_cin, rsp_id, rsp_sum, rsp_cout} !== 19'b0) begin
      failures++;
      $display("FAIL reset_outputs: x=%0d y=%0d cin=%b id=%0d sum=%0d cout=%b, want all 0",
               add_x, add_y, add_cin, rsp_id, rsp_sum, rsp_cout);
    end
  endtask

  task automatic test_single();
    req_x[0 +: 5] = 5'd12;
    req_y[0 +: 5] = 5'd7;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL single_grant: req_ready=%b want 0001", req_ready);
    end
    tick();
    req_valid = 4'b0;
    checks++;
    if (req_ready !== 4'b0 || add_x !== 5'd12 || add_y !== 5'd7 || add_cin !== 1'b0) begin
      failures++;
      $display("FAIL single_drive: ready=%b x=%0d y=%0d cin=%b want 0000/12/7/0", req_ready, add_x, add_y, add_cin);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL single_early: rsp_valid=%b at E0+1 want 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 5'd19 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL single_rsp: v=%b sum=%0d cout=%b id=%0d want 1/19/0/0", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL single_done: rsp_valid=%b want 0", rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [4:0] xs [2] = '{5'd31, 5'd20};
    logic [4:0] ys [2] = '{5'd1,  5'd15};
    logic [4:0] es [2] = '{5'd0,  5'd3};
    for (int v = 0; v < 2; v++) begin
      req_x[10 +: 5] = xs[v];
      req_y[10 +: 5] = ys[v];
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
        failures++; $display("FAIL ovf_grant%0d: req_ready=%b want 0100", v, req_ready);
      end
      tick();
      req_valid = 4'b0;
      tick();
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== es[v] || rsp_cout !== 1'b1 || rsp_id !== 2'd2) begin
        failures++;
        $display("FAIL ovf_rsp%0d: v=%b sum=%0d cout=%b id=%0d want 1/%0d/1/2", v, rsp_valid, rsp_sum, rsp_cout, rsp_id, es[v]);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++; $display("FAIL ovf_done%0d: rsp_valid=%b want 0", v, rsp_valid);
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_fairness();
    int         exp_id  [5] = '{0, 1, 2, 3, 0};
    logic [4:0] exp_sum [4] = '{5'd7, 5'd20, 5'd5, 5'd3};
    logic       exp_c   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int gid [5];
    int gcyc [5];
    int rid [5];
    logic [4:0] rs [5];
    logic rc [5];
    int grants = 0;
    int rsps = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req_x = {5'd30, 5'd17, 5'd9, 5'd3};
    req_y = {5'd5, 5'd20, 5'd11, 5'd4};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 60 && rsps < 5; cyc++) begin
      if (grants >= 5) req_valid = 4'b0;
      if (req_ready != 4'b0 && grants < 5) begin
        checks++;
        if (!$onehot(req_ready)) begin
          failures++; $display("FAIL fair_onehot: req_ready=%b", req_ready);
        end
        for (int j = 0; j < 4; j++) if (req_ready[j]) gid[grants] = j;
        gcyc[grants] = cyc;
        grants++;
      end
      if (rsp_valid === 1'b1) begin
        rid[rsps] = int'(rsp_id);
        rs[rsps] = rsp_sum;
        rc[rsps] = rsp_cout;
        rsps++;
      end
      if (rsps < 5) tick();
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsps != 5 || grants != 5) begin
      failures++; $display("FAIL fair_timeout: grants=%0d rsps=%0d want 5/5", grants, rsps);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (gid[i] != exp_id[i] || rid[i] != exp_id[i] ||
            rs[i] !== exp_sum[exp_id[i]] || rc[i] !== exp_c[exp_id[i]]) begin
          failures++;
          $display("FAIL fair_op%0d: grant=%0d id=%0d sum=%0d cout=%b want %0d/%0d/%0d/%b",
                   i, gid[i], rid[i], rs[i], rc[i], exp_id[i], exp_id[i], exp_sum[exp_id[i]], exp_c[exp_id[i]]);
        end
        if (i > 0) begin
          checks++;
          if (gcyc[i] - gcyc[i-1] != 4) begin
            failures++; $display("FAIL fair_spacing%0d: gap=%0d want 4", i, gcyc[i] - gcyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    req_x[5 +: 5] = 5'd5;
    req_y[5 +: 5] = 5'd6;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL bp_grant: req_ready=%b want 0010", req_ready);
    end
    tick();
    req_x[15 +: 5] = 5'd2;
    req_y[15 +: 5] = 5'd2;
    req_valid = 4'b1000;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 5'd11 || rsp_cout !== 1'b0 || rsp_id !== 2'd1 || req_ready !== 4'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: v=%b sum=%0d cout=%b id=%0d ready=%b want 1/11/0/1/0000",
                 k, rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      failures++; $display("FAIL bp_release: v=%b ready=%b want 0/1000", rsp_valid, req_ready);
    end
    req_valid = 4'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_x[10 +: 5] = 5'd7;
    req_y[10 +: 5] = 5'd8;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL rst_grant: req_ready=%b want 0100", req_ready);
    end
    tick();
    req_valid = 4'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, add_x, add_y, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout} !== 24'b0) begin
      failures++;
      $display("FAIL rst_async: ready=%b x=%0d y=%0d cin=%b v=%b id=%0d sum=%0d cout=%b want all 0",
               req_ready, add_x, add_y, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++; $display("FAIL rst_no_rsp%0d: rsp_valid=%b want 0", c, rsp_valid);
      end
    end
    req_x[5 +: 5] = 5'd9;
    req_y[5 +: 5] = 5'd9;
    req_x[15 +: 5] = 5'd1;
    req_y[15 +: 5] = 5'd1;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL rst_ptr: req_ready=%b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b0;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 5'd18 || rsp_cout !== 1'b0 || rsp_id !== 2'd1) begin
      failures++;
      $display("FAIL rst_after: v=%b sum=%0d cout=%b id=%0d want 1/18/0/1", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_after_done: rsp_valid=%b want 0", rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
